// File: rtl/v_rams_02b_dmem.sv
// Byte-addressable 32-bit data memory: asynchronous word read, synchronous word/byte store.
// Optional macro HALFWORD_STORE_EN turns we=2'b10 into a halfword store.
module v_rams_02b_dmem #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] indata,
    input  logic [31:0] daddr,
    input  logic [1:0]  we,
    output logic [31:0] outdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        WE_READ = 2'b00,
        WE_WORD = 2'b01,
        WE_HALF = 2'b10,
        WE_BYTE = 2'b11
    } we_mode_e;

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_lane;
    we_mode_e              mode;
    logic                  unused_addr_bits;

    // Upper address bits are dropped, so addresses alias modulo the depth.
    assign word_idx         = daddr[ADDR_WIDTH+1:2];
    assign byte_lane        = daddr[1:0];
    assign mode             = we_mode_e'(we);
    assign unused_addr_bits = ^daddr[31:ADDR_WIDTH+2];

    assign outdata = mem_q[word_idx];

    // NOTE: start from the current contents so every path assigns mem_d and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        case (mode)
            WE_WORD: mem_d[word_idx] = indata;
            WE_BYTE: mem_d[word_idx][{byte_lane, 3'b000} +: 8] = indata[7:0];
`ifdef HALFWORD_STORE_EN
            WE_HALF: mem_d[word_idx][{byte_lane[1], 4'b0000} +: 16] = indata[15:0];
`endif
            default: ;
        endcase
    end

    // NOTE: the array is a plain register file, so it can be (and must be) cleared by reset;
    // non-blocking assignments keep the read path showing old data until the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_v_rams_02b_dmem.sv
// Scoreboard bench for v_rams_02b_dmem: stimulus queues expected read data, a monitor compares.
// Expectations for we=2'b10 follow the HALFWORD_STORE_EN macro.
module tb_v_rams_02b_dmem;

    logic        clk;
    logic        rst;
    logic [31:0] indata;
    logic [31:0] daddr;
    logic [1:0]  we;
    logic [31:0] outdata;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int        checks = 0;
    int        errors = 0;
    bit        stim_done = 0;

    v_rams_02b_dmem #(.ADDR_WIDTH(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .indata (indata),
        .daddr  (daddr),
        .we     (we),
        .outdata(outdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; after the edge, queue the value outdata must show.
    task automatic op(input string name, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] w, input logic r, input logic [31:0] exp);
        daddr  = a;
        indata = d;
        we     = w;
        rst    = r;
        @(posedge clk);
        #1;
        exp_q.push_back('{name: name, exp: exp});
        @(negedge clk);
        #1;
    endtask

    // Monitor: outdata is valid mid-cycle after each edge; compare against the queue head.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, outdata, e.exp);
            end
        end
    end

    initial begin
        daddr = '0; indata = '0; we = 2'b00; rst = 1'b1;
        @(negedge clk);
        #1;
        op("reset_word0",   32'h0000_0000, 32'h0,         2'b00, 1'b1, 32'h0000_0000);
        op("reset_word3f",  32'h0000_00FC, 32'h0,         2'b00, 1'b0, 32'h0000_0000);
        op("word_write",    32'h0000_0000, 32'h0403_0201, 2'b01, 1'b0, 32'h0403_0201);
        op("byte_lane2",    32'h0000_0002, 32'h0406_0202, 2'b11, 1'b0, 32'h0402_0201);
`ifdef HALFWORD_STORE_EN
        op("we10_half_hi",  32'h0000_0002, 32'h0000_BEEF, 2'b10, 1'b0, 32'hBEEF_0201);
`else
        op("we10_no_write", 32'h0000_0002, 32'h0000_BEEF, 2'b10, 1'b0, 32'h0402_0201);
`endif
        op("byte_fresh",    32'h0000_00A2, 32'h0403_0202, 2'b11, 1'b0, 32'h0002_0000);
        op("read_no_write", 32'h0000_00A2, 32'h1234_5678, 2'b00, 1'b0, 32'h0002_0000);
        op("alias_write",   32'h0010_0004, 32'h1234_5678, 2'b01, 1'b0, 32'h1234_5678);
        op("alias_read4",   32'h0000_0004, 32'h0,         2'b00, 1'b0, 32'h1234_5678);
        op("alias_read104", 32'h0000_0104, 32'h0,         2'b00, 1'b0, 32'h1234_5678);
        op("byte_lane1",    32'h0000_0005, 32'hFFFF_FFAB, 2'b11, 1'b0, 32'h1234_AB78);
        op("byte_lane3",    32'h0000_0007, 32'h0000_00CD, 2'b11, 1'b0, 32'hCD34_AB78);
        op("word_misalign", 32'h0000_000B, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'hDEAD_BEEF);
        op("misalign_rd8",  32'h0000_0008, 32'h0,         2'b00, 1'b0, 32'hDEAD_BEEF);
        op("last_word",     32'h0000_00FC, 32'hA5A5_A5A5, 2'b01, 1'b0, 32'hA5A5_A5A5);
        op("last_alias",    32'h0000_01FC, 32'h0,         2'b00, 1'b0, 32'hA5A5_A5A5);
        op("last_lane0",    32'h0000_00FC, 32'h0000_0011, 2'b11, 1'b0, 32'hA5A5_A511);
        op("rst_drops_wr",  32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0000_0000);
        op("rst_clr_4",     32'h0000_0004, 32'h0,         2'b00, 1'b0, 32'h0000_0000);
        op("rst_clr_a0",    32'h0000_00A0, 32'h0,         2'b00, 1'b0, 32'h0000_0000);
        op("rst_clr_fc",    32'h0000_00FC, 32'h0,         2'b00, 1'b0, 32'h0000_0000);
        op("post_rst_wr",   32'h0000_0000, 32'h5A5A_5A5A, 2'b01, 1'b0, 32'h5A5A_5A5A);
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
